// File: rtl/fact_arbiter.sv
`timescale 1ns/1ps
// fact_arbiter
// Round-robin front end that time-shares one Factorial engine (go/done
// handshake) among NREQ requesters. The winner's operand is latched and
// held on eng_in for the whole operation. The arbiter only accepts a done
// that follows a low phase, so a done level left over from the previous
// operation is never mistaken for a new result. The result goes back to
// the owner over a one-hot valid/ack handshake. A saturating cycle counter
// turns a silent engine into an error response.
module fact_arbiter #(
  parameter int NREQ  = 4,
  parameter int IWIDE = 4,
  parameter int OWIDE = 32,
  parameter int TMAX  = 1023
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*IWIDE-1:0]   req_in,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ack,
  output logic [OWIDE-1:0]        resp_data,
  output logic                    resp_err,
  output logic                    eng_go,
  output logic [IWIDE-1:0]        eng_in,
  input  logic                    eng_done,
  input  logic [OWIDE-1:0]        eng_out,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_grantIdx;
  logic [NREQ-1:0]   r_grant;
  logic [IWIDE-1:0]  r_engIn;
  logic [OWIDE-1:0]  r_respData;
  logic              r_respErr;
  logic [CW-1:0]     r_cnt;

  logic [IWIDE-1:0]  w_operand [NREQ];
  logic              w_found;
  logic [PW-1:0]     w_pickIdx;
  logic [PW-1:0]     w_cand;
  logic              w_cntHit;
  logic              w_loadGrant;
  logic              w_release;
  logic              w_capture;
  logic              w_timeout;
  logic              w_cntClr;
  logic              w_cntInc;

  // Slice the flat operand bus into one operand per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_operand
      assign w_operand[gi] = req_in[gi*IWIDE +: IWIDE];
    end
  endgenerate

  // Round-robin search: the first set req bit starting at the pointer, wrapping around.
  always_comb begin
    w_found   = 1'b0;
    w_pickIdx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        w_pickIdx = w_cand;
      end
    end
  end

  // The timeout fires on the last allowed wait cycle, so RESP is entered TMAX cycles after WAIT_LO entry.
  assign w_cntHit = (r_cnt >= CW'(TMAX - 1));

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    w_nextState = r_state;
    w_loadGrant = 1'b0;
    w_release   = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_cntClr    = 1'b0;
    w_cntInc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_loadGrant = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_cntClr    = 1'b1;
        w_nextState = WAIT_LO;
      end
      WAIT_LO: begin
        w_cntInc = 1'b1;
        if (w_cntHit) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end else if (!eng_done) begin
          w_nextState = WAIT_HI;
        end
      end
      WAIT_HI: begin
        w_cntInc = 1'b1;
        if (eng_done) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end else if (w_cntHit) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (resp_ack[r_grantIdx] || !req[r_grantIdx]) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Grant, pointer, latched operand and response registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ptr      <= '0;
      r_grantIdx <= '0;
      r_grant    <= '0;
      r_engIn    <= '0;
      r_respData <= '0;
      r_respErr  <= 1'b0;
    end else begin
      if (w_loadGrant) begin
        r_grant    <= ONE_HOT0 << w_pickIdx;
        r_grantIdx <= w_pickIdx;
        r_engIn    <= w_operand[w_pickIdx];
      end
      if (w_capture) begin
        r_respData <= eng_out;
        r_respErr  <= 1'b0;
      end
      if (w_timeout) begin
        r_respData <= '0;
        r_respErr  <= 1'b1;
      end
      if (w_release) begin
        r_grant <= '0;
        if (r_grantIdx == PW'(NREQ - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_grantIdx + 1'b1;
        end
      end
    end
  end

  // Wait-cycle counter. It saturates at TMAX instead of wrapping.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (w_cntClr) begin
      r_cnt <= '0;
    end else if (w_cntInc && (r_cnt != CW'(TMAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign grant      = r_grant;
  assign resp_valid = (r_state == RESP) ? r_grant : '0;
  assign resp_data  = r_respData;
  assign resp_err   = r_respErr;
  assign eng_go     = (r_state == ISSUE);
  assign eng_in     = r_engIn;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fact_arbiter.sv
`timescale 1ns/1ps
// Directed bench for fact_arbiter with a behavioural Factorial engine model
// that can also hold a stale done level or never answer.
module tb_fact_arbiter;

  localparam int NREQ  = 4;
  localparam int IWIDE = 4;
  localparam int OWIDE = 32;
  localparam int TMAX  = 16;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*IWIDE-1:0] req_in;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ack;
  logic [OWIDE-1:0]      resp_data;
  logic                  resp_err;
  logic                  eng_go;
  logic [IWIDE-1:0]      eng_in;
  logic                  eng_done = 1'b0;
  logic [OWIDE-1:0]      eng_out = '0;
  logic                  busy;

  int passCount;
  int checkCount;

  bit   staleMode;
  bit   hangMode;
  logic [IWIDE-1:0] engOp = '0;
  int   engCnt = 0;
  bit   engRun = 1'b0;
  int   staleLeft = 0;
  int   goCount = 0;

  fact_arbiter #(.NREQ(NREQ), .IWIDE(IWIDE), .OWIDE(OWIDE), .TMAX(TMAX)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req        (req),
    .req_in     (req_in),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_ack   (resp_ack),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .eng_go     (eng_go),
    .eng_in     (eng_in),
    .eng_done   (eng_done),
    .eng_out    (eng_out),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] factOf(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  // Engine model: latches the operand on go and answers after a fixed latency.
  // Once raised, done stays high until the next go, like the real Factorial.
  always @(posedge Clk) begin
    if (eng_go === 1'b1) begin
      engOp  <= eng_in;
      engCnt <= 4;
      engRun <= 1'b1;
      if (staleMode) begin
        staleLeft <= 5;
      end else begin
        staleLeft <= 0;
        eng_done  <= 1'b0;
      end
    end else if (staleLeft > 0) begin
      staleLeft <= staleLeft - 1;
      if (staleLeft == 1) eng_done <= 1'b0;
    end else if (engRun && !hangMode) begin
      if (engCnt <= 1) begin
        eng_done <= 1'b1;
        eng_out  <= factOf(int'(engOp));
        engRun   <= 1'b0;
      end else begin
        engCnt <= engCnt - 1;
      end
    end
  end

  // Count go pulses so the bench can confirm that each operation issues exactly one.
  always @(posedge Clk) begin
    if (eng_go === 1'b1) goCount <= goCount + 1;
  end

  task automatic waitValid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      if (resp_valid !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; req = '0; req_in = '0; resp_ack = '0;
    staleMode = 1'b0; hangMode = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checkCount++;
    if ({grant, resp_valid, eng_go, eng_in, resp_data, resp_err, busy} !== '0)
      $display("[TB] FAIL reset_outputs: got %0h want 0",
               {grant, resp_valid, eng_go, eng_in, resp_data, resp_err, busy});
    else passCount++;
    Rst = 1'b1;
    @(negedge Clk);
    checkCount++;
    if (busy !== 1'b0 || grant !== '0)
      $display("[TB] FAIL idle_after_reset: busy=%0b grant=%b want 0/0000", busy, grant);
    else passCount++;
  endtask

  task automatic test_single();
    bit ok;
    int goBase;
    goBase = goCount;
    req = 4'b0001; req_in[3:0] = 4'd5;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b0001 || eng_go !== 1'b1 || eng_in !== 4'd5)
      $display("[TB] FAIL single_grant: grant=%b go=%0b in=%0d want 0001/1/5", grant, eng_go, eng_in);
    else passCount++;
    waitValid(40, ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL single_valid_timeout: got no resp_valid want 0001");
    else passCount++;
    checkCount++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'd120 || resp_err !== 1'b0)
      $display("[TB] FAIL single_result: valid=%b data=%0d err=%0b want 0001/120/0",
               resp_valid, resp_data, resp_err);
    else passCount++;
    @(negedge Clk);
    checkCount++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'd120)
      $display("[TB] FAIL single_hold: valid=%b data=%0d want 0001/120", resp_valid, resp_data);
    else passCount++;
    checkCount++;
    if (goCount - goBase !== 1)
      $display("[TB] FAIL single_go_pulses: got %0d want 1", goCount - goBase);
    else passCount++;
    resp_ack = 4'b0001; req = '0;
    @(negedge Clk);
    resp_ack = '0;
    checkCount++;
    if (busy !== 1'b0 || grant !== '0 || resp_valid !== '0)
      $display("[TB] FAIL single_release: busy=%0b grant=%b valid=%b want 0/0000/0000",
               busy, grant, resp_valid);
    else passCount++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] rrExp [4];
    rrExp = '{32'd6, 32'd24, 32'd720, 32'd479001600};
    doReset();
    req_in = {4'd12, 4'd6, 4'd4, 4'd3};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      waitValid(40, ok);
      checkCount++;
      if (!ok || resp_valid !== (4'b0001 << k) || resp_data !== rrExp[k])
        $display("[TB] FAIL rr_result_%0d: valid=%b data=%0d want %b/%0d",
                 k, resp_valid, resp_data, 4'b0001 << k, rrExp[k]);
      else passCount++;
      resp_ack = 4'b0001 << k;
      @(negedge Clk);
      resp_ack = '0;
      checkCount++;
      if (busy !== 1'b0 || eng_go !== 1'b0)
        $display("[TB] FAIL rr_gap_idle_%0d: busy=%0b go=%0b want 0/0", k, busy, eng_go);
      else passCount++;
      @(negedge Clk);
      checkCount++;
      if (eng_go !== 1'b1 || grant !== (4'b0001 << ((k + 1) % 4)))
        $display("[TB] FAIL rr_next_grant_%0d: go=%0b grant=%b want 1/%b",
                 k, eng_go, grant, 4'b0001 << ((k + 1) % 4));
      else passCount++;
    end
    req = 4'b0001;
    waitValid(40, ok);
    checkCount++;
    if (!ok || resp_data !== 32'd6)
      $display("[TB] FAIL rr_wrap_result: data=%0d want 6", resp_data);
    else passCount++;
    resp_ack = 4'b0001; req = '0;
    @(negedge Clk);
    resp_ack = '0;
  endtask

  task automatic test_stale_done();
    bit ok;
    bit early;
    staleMode = 1'b1;
    req = 4'b0010; req_in[7:4] = 4'd7;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b0010 || eng_done !== 1'b1)
      $display("[TB] FAIL stale_grant: grant=%b done=%0b want 0010/1", grant, eng_done);
    else passCount++;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (resp_valid !== '0) early = 1'b1;
    end
    checkCount++;
    if (early) $display("[TB] FAIL stale_early_capture: got valid during stale done want none");
    else passCount++;
    waitValid(30, ok);
    checkCount++;
    if (!ok || resp_data !== 32'd5040 || resp_err !== 1'b0)
      $display("[TB] FAIL stale_result: data=%0d err=%0b want 5040/0", resp_data, resp_err);
    else passCount++;
    resp_ack = 4'b0010; req = '0;
    @(negedge Clk);
    resp_ack = '0;
    staleMode = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    hangMode = 1'b1;
    req = 4'b0100; req_in[11:8] = 4'd9;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b0100) $display("[TB] FAIL timeout_grant: got %b want 0100", grant);
    else passCount++;
    @(negedge Clk);
    early = (resp_valid !== '0);
    for (int i = 1; i < TMAX; i++) begin
      @(negedge Clk);
      if (resp_valid !== '0) early = 1'b1;
    end
    checkCount++;
    if (early) $display("[TB] FAIL timeout_early: got valid before %0d cycles want none", TMAX);
    else passCount++;
    @(negedge Clk);
    checkCount++;
    if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_data !== '0)
      $display("[TB] FAIL timeout_response: valid=%b err=%0b data=%0d want 0100/1/0",
               resp_valid, resp_err, resp_data);
    else passCount++;
    resp_ack = 4'b0100; req = '0;
    @(negedge Clk);
    resp_ack = '0;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL timeout_release: busy=%0b want 0", busy);
    else passCount++;
    req = 4'b1100; req_in[15:12] = 4'd2;
    @(negedge Clk);
    hangMode = 1'b0;
    checkCount++;
    if (grant !== 4'b1000) $display("[TB] FAIL timeout_ptr_advance: grant=%b want 1000", grant);
    else passCount++;
    req = 4'b1000;
    waitValid(40, ok);
    checkCount++;
    if (!ok || resp_data !== 32'd2 || resp_err !== 1'b0)
      $display("[TB] FAIL after_timeout_result: data=%0d err=%0b want 2/0", resp_data, resp_err);
    else passCount++;
    resp_ack = 4'b1000; req = '0;
    @(negedge Clk);
    resp_ack = '0;
  endtask

  task automatic test_cancel();
    bit ok;
    req = 4'b0100; req_in[11:8] = 4'd10;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b0100 || eng_in !== 4'd10)
      $display("[TB] FAIL cancel_grant: grant=%b in=%0d want 0100/10", grant, eng_in);
    else passCount++;
    req_in[11:8] = 4'd3;
    @(negedge Clk);
    checkCount++;
    if (eng_in !== 4'd10) $display("[TB] FAIL operand_hold: eng_in=%0d want 10", eng_in);
    else passCount++;
    waitValid(40, ok);
    checkCount++;
    if (!ok || resp_data !== 32'd3628800)
      $display("[TB] FAIL cancel_result: data=%0d want 3628800", resp_data);
    else passCount++;
    resp_ack = 4'b0001;
    @(negedge Clk);
    resp_ack = '0;
    checkCount++;
    if (resp_valid !== 4'b0100)
      $display("[TB] FAIL foreign_ack_ignored: valid=%b want 0100", resp_valid);
    else passCount++;
    req = '0;
    @(negedge Clk);
    checkCount++;
    if (resp_valid !== '0 || grant !== '0 || busy !== 1'b0)
      $display("[TB] FAIL cancel_release: valid=%b grant=%b busy=%0b want 0000/0000/0",
               resp_valid, grant, busy);
    else passCount++;
    req = 4'b1001; req_in[15:12] = 4'd2;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b1000) $display("[TB] FAIL cancel_ptr: grant=%b want 1000", grant);
    else passCount++;
  endtask

  task automatic test_async_reset();
    bit ok;
    @(negedge Clk);
    @(negedge Clk);
    checkCount++;
    if (busy !== 1'b1 || resp_valid !== '0)
      $display("[TB] FAIL pre_reset_wait: busy=%0b valid=%b want 1/0000", busy, resp_valid);
    else passCount++;
    #2;
    Rst = 1'b0;
    #1;
    checkCount++;
    if ({grant, resp_valid, eng_go, eng_in, resp_data, resp_err, busy} !== '0)
      $display("[TB] FAIL async_reset_outputs: got %0h want 0",
               {grant, resp_valid, eng_go, eng_in, resp_data, resp_err, busy});
    else passCount++;
    // Requester 3 is also asking: a pointer left at 3 would pick it instead of requester 1.
    req = 4'b1010;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checkCount++;
    if (grant !== 4'b0010) $display("[TB] FAIL reset_ptr: grant=%b want 0010", grant);
    else passCount++;
    req = 4'b0010;
    waitValid(40, ok);
    checkCount++;
    if (!ok || resp_data !== 32'd5040)
      $display("[TB] FAIL post_reset_result: data=%0d want 5040", resp_data);
    else passCount++;
    resp_ack = 4'b0010; req = '0;
    @(negedge Clk);
    resp_ack = '0;
  endtask

  initial begin
    passCount = 0;
    checkCount = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_cancel();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at 100000ns want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
